// File: rtl/spike_tx_pkg.sv
// Shared definitions for the spike word serializer and its receive-side deserializer.
// Byte order is fixed here: the low IO_WIDTH slice of a word goes out first.
package spike_tx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam int unsigned DEF_IO_WIDTH  = 8;
  localparam int unsigned DEF_CNT_WIDTH = 1;

  function automatic int unsigned word_width(input int unsigned io_w, input int unsigned cnt_w);
    return io_w << cnt_w;
  endfunction

  function automatic int unsigned beats_per_word(input int unsigned cnt_w);
    return 32'd1 << cnt_w;
  endfunction

endpackage

// File: rtl/spike_tx_frame_cnt.sv
// Frame position counters (t innermost, then column, then row) and last-word flag.
module spike_tx_frame_cnt
  import spike_tx_pkg::*;
#(
  parameter int unsigned HW_WIDTH = 5,
  parameter int unsigned T_WIDTH  = 5
) (
  input  logic                CLK,
  input  logic                RSTB,
  input  logic                load_i,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic [HW_WIDTH-1:0] hw_i,
  input  logic [T_WIDTH-1:0]  t_i,
  output logic                last_c_o
);

  logic [HW_WIDTH-1:0] hw_q, hw_d;
  logic [T_WIDTH-1:0]  t_max_q, t_max_d;
  logic [T_WIDTH-1:0]  t_q, t_d;
  logic [HW_WIDTH-1:0] col_q, col_d;
  logic [HW_WIDTH-1:0] row_q, row_d;

  always_comb begin
    hw_d    = hw_q;
    t_max_d = t_max_q;
    t_d     = t_q;
    col_d   = col_q;
    row_d   = row_q;
    if (load_i) begin
      hw_d    = hw_i;
      t_max_d = t_i;
      t_d     = '0;
      col_d   = '0;
      row_d   = '0;
    end else if (clr_i) begin
      t_d   = '0;
      col_d = '0;
      row_d = '0;
    end else if (inc_i) begin
      // Odometer walk: t wraps into column, column wraps into row.
      if (t_q != t_max_q) begin
        t_d = T_WIDTH'(t_q + T_WIDTH'(1));
      end else begin
        t_d = '0;
        if (col_q != hw_q) begin
          col_d = HW_WIDTH'(col_q + HW_WIDTH'(1));
        end else begin
          col_d = '0;
          row_d = (row_q == hw_q) ? '0 : HW_WIDTH'(row_q + HW_WIDTH'(1));
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      hw_q    <= '0;
      t_max_q <= '0;
      t_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      hw_q    <= hw_d;
      t_max_q <= t_max_d;
      t_q     <= t_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign last_c_o = (t_q == t_max_q) && (col_q == hw_q) && (row_q == hw_q);

endmodule

// File: rtl/spike_tx.sv
// Host-side spike word transmitter: valid/ready words in, IN_VALID/IN_SPIKE beats out,
// with frame counting, programmable inter-word gap and a frame-done pulse.
module spike_tx
  import spike_tx_pkg::*;
#(
  parameter int unsigned IO_WIDTH   = DEF_IO_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int unsigned HW_WIDTH   = 5,
  parameter int unsigned T_WIDTH    = 5,
  parameter int unsigned GAP_WIDTH  = 4,
  localparam int unsigned WORD_WIDTH = word_width(IO_WIDTH, CNT_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [HW_WIDTH-1:0]   HW,
  input  logic [T_WIDTH-1:0]    T,
  input  logic [GAP_WIDTH-1:0]  GAP,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic [WORD_WIDTH-1:0] S_SPIKE,
  output logic                  OUT_VALID,
  output logic [IO_WIDTH-1:0]   OUT_SPIKE,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [CNT_WIDTH-1:0] BEAT_LAST = CNT_WIDTH'(beats_per_word(CNT_WIDTH) - 1);

  logic [1:0]            state_q, state_d;
  logic                  s_ready_q, s_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [IO_WIDTH-1:0]   out_spike_q, out_spike_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [GAP_WIDTH-1:0]  gap_len_q, gap_len_d;
  logic                  last_word_q, last_word_d;

  logic accept_c;
  logic load_word_c;
  logic cnt_load_c, cnt_clr_c, cnt_inc_c, cnt_last_c;

  assign accept_c = S_VALID & s_ready_q;

  spike_tx_frame_cnt #(
    .HW_WIDTH (HW_WIDTH),
    .T_WIDTH  (T_WIDTH)
  ) u_frame_cnt (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .load_i   (cnt_load_c),
    .clr_i    (cnt_clr_c),
    .inc_i    (cnt_inc_c),
    .hw_i     (HW),
    .t_i      (T),
    .last_c_o (cnt_last_c)
  );

  // Next-state and registered-output logic; S_READY is pre-computed one cycle ahead.
  always_comb begin
    state_d     = state_q;
    s_ready_d   = 1'b0;
    out_valid_d = 1'b0;
    out_spike_d = '0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    shift_d     = shift_q;
    beat_d      = beat_q;
    gap_cnt_d   = gap_cnt_q;
    gap_len_d   = gap_len_q;
    last_word_d = last_word_q;
    load_word_c = 1'b0;
    cnt_load_c  = 1'b0;
    cnt_clr_c   = 1'b0;
    cnt_inc_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d     = ST_LOAD;
          busy_d      = 1'b1;
          s_ready_d   = 1'b1;
          gap_len_d   = GAP;
          last_word_d = 1'b0;
          cnt_load_c  = 1'b1;
        end
      end
      ST_LOAD: begin
        s_ready_d = 1'b1;
        if (accept_c) load_word_c = 1'b1;
      end
      ST_SEND: begin
        if (beat_q != BEAT_LAST) begin
          beat_d      = CNT_WIDTH'(beat_q + CNT_WIDTH'(1));
          out_valid_d = 1'b1;
          out_spike_d = shift_q[IO_WIDTH-1:0];
          shift_d     = shift_q >> IO_WIDTH;
          s_ready_d   = (CNT_WIDTH'(beat_q + CNT_WIDTH'(1)) == BEAT_LAST) &&
                        !last_word_q && (gap_len_q == '0);
        end else if (last_word_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (gap_len_q == '0) begin
          if (accept_c) begin
            load_word_c = 1'b1;
          end else begin
            state_d   = ST_LOAD;
            s_ready_d = 1'b1;
          end
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_WIDTH'(1);
          s_ready_d = (gap_len_q == GAP_WIDTH'(1));
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == gap_len_q) begin
          if (accept_c) begin
            load_word_c = 1'b1;
          end else begin
            state_d   = ST_LOAD;
            s_ready_d = 1'b1;
          end
        end else begin
          gap_cnt_d = GAP_WIDTH'(gap_cnt_q + GAP_WIDTH'(1));
          s_ready_d = (GAP_WIDTH'(gap_cnt_q + GAP_WIDTH'(1)) == gap_len_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Word capture: first beat goes straight to the output register.
    if (load_word_c) begin
      state_d     = ST_SEND;
      out_valid_d = 1'b1;
      out_spike_d = S_SPIKE[IO_WIDTH-1:0];
      shift_d     = S_SPIKE >> IO_WIDTH;
      beat_d      = '0;
      last_word_d = cnt_last_c;
      cnt_inc_c   = 1'b1;
      s_ready_d   = (BEAT_LAST == '0) && !cnt_last_c && (gap_len_q == '0);
    end

    if (ABORT) begin
      state_d     = ST_IDLE;
      s_ready_d   = 1'b0;
      out_valid_d = 1'b0;
      out_spike_d = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      shift_d     = '0;
      beat_d      = '0;
      gap_cnt_d   = '0;
      last_word_d = 1'b0;
      cnt_load_c  = 1'b0;
      cnt_inc_c   = 1'b0;
      cnt_clr_c   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_spike_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shift_q     <= '0;
      beat_q      <= '0;
      gap_cnt_q   <= '0;
      gap_len_q   <= '0;
      last_word_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      out_valid_q <= out_valid_d;
      out_spike_q <= out_spike_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      shift_q     <= shift_d;
      beat_q      <= beat_d;
      gap_cnt_q   <= gap_cnt_d;
      gap_len_q   <= gap_len_d;
      last_word_q <= last_word_d;
    end
  end

  assign S_READY   = s_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_SPIKE = out_spike_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_spike_tx.sv
// Scoreboard bench for spike_tx: driver pushes expected beats on each handshake,
// an independent monitor pops and compares every OUT_VALID beat.
module tb_spike_tx;

  logic        CLK = 1'b0;
  logic        RSTB = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [4:0]  HW = '0;
  logic [4:0]  T = '0;
  logic [3:0]  GAP = '0;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [15:0] S_SPIKE = '0;
  logic        OUT_VALID;
  logic [7:0]  OUT_SPIKE;
  logic        BUSY;
  logic        DONE;

  spike_tx dut (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .START     (START),
    .ABORT     (ABORT),
    .HW        (HW),
    .T         (T),
    .GAP       (GAP),
    .S_VALID   (S_VALID),
    .S_READY   (S_READY),
    .S_SPIKE   (S_SPIKE),
    .OUT_VALID (OUT_VALID),
    .OUT_SPIKE (OUT_SPIKE),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] wq[$];
  int          gapq[$];
  logic [7:0]  maskq[$];
  int          done_cnt = 0;
  int          frame_beats = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop, bubble detection, gap/ready-pattern capture, DONE timing.
  initial begin : monitor
    logic       pos;
    logic       seen_beat;
    logic       prev_valid;
    int         low_run;
    logic [7:0] rdy_mask;
    logic [7:0] exp_b;
    pos = 1'b0; seen_beat = 1'b0; prev_valid = 1'b0; low_run = 0; rdy_mask = '0;
    forever begin
      @(negedge CLK);
      if (OUT_VALID) begin
        frame_beats++;
        if (seen_beat && low_run > 0) begin
          gapq.push_back(low_run);
          maskq.push_back(rdy_mask);
        end
        low_run = 0; rdy_mask = '0; seen_beat = 1'b1; pos = ~pos;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL beat_unexpected: got 0x%0h, expected no beat (t=%0t)", OUT_SPIKE, $time);
        end else begin
          exp_b = exp_q.pop_front();
          check("beat_data", 32'(OUT_SPIKE), 32'(exp_b));
        end
      end else begin
        check("idle_spike_zero", 32'(OUT_SPIKE), 32'd0);
        if (BUSY) begin
          check("no_mid_word_bubble", 32'(pos), 32'd0);
          if (seen_beat) begin
            if (low_run < 8) rdy_mask[low_run[2:0]] = S_READY;
            low_run++;
          end
        end else begin
          pos = 1'b0; seen_beat = 1'b0; low_run = 0; rdy_mask = '0;
        end
      end
      if (DONE) begin
        done_cnt++;
        check("done_after_last_beat", 32'(prev_valid), 32'd1);
        check("busy_low_with_done", 32'(BUSY), 32'd0);
      end
      prev_valid = OUT_VALID;
    end
  end

  task automatic push_word(input logic [15:0] w, input bit rnd);
    int budget;
    budget = 0;
    S_SPIKE = w;
    S_VALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!(S_VALID && S_READY)) begin
      @(negedge CLK);
      budget++;
      if (budget > 200) begin
        n_cmp++; n_err++;
        $display("FAIL handshake_timeout: word 0x%0h not accepted, expected within 200 cycles", w);
        S_VALID = 1'b0;
        return;
      end
      if (rnd) S_VALID = 1'($urandom_range(0, 1));
    end
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    @(negedge CLK);
    S_VALID = 1'b0;
  endtask

  task automatic start_frame(input logic [4:0] hw, input logic [4:0] t, input logic [3:0] gap);
    @(negedge CLK);
    HW = hw; T = t; GAP = gap; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_start", 32'(BUSY), 32'd1);
    check("ready_after_start", 32'(S_READY), 32'd1);
  endtask

  task automatic finish_frame(input int dn0, input int nwords);
    int budget;
    budget = 0;
    while (done_cnt == dn0 && budget < 100) begin
      check("ready_after_last_word", 32'(S_READY), 32'd0);
      @(negedge CLK);
      budget++;
    end
    if (done_cnt == dn0) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: no DONE within 100 cycles, expected one");
    end
    repeat (3) @(negedge CLK);
    check("done_count", 32'(done_cnt - dn0), 32'd1);
    check("frame_beats", 32'(frame_beats), 32'(2 * nwords));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("ready_low_idle", 32'(S_READY), 32'd0);
    check("busy_low_idle", 32'(BUSY), 32'd0);
  endtask

  // Runs a whole frame from the words in wq.
  task automatic run_frame(input logic [4:0] hw, input logic [4:0] t, input logic [3:0] gap,
                           input bit rnd);
    int dn0;
    dn0 = done_cnt;
    frame_beats = 0;
    gapq.delete();
    maskq.delete();
    start_frame(hw, t, gap);
    foreach (wq[i]) push_word(wq[i], rnd);
    finish_frame(dn0, wq.size());
  endtask

  initial begin : stim
    int dn0;
    repeat (2) @(negedge CLK);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_out_spike", 32'(OUT_SPIKE), 32'd0);
    check("rst_s_ready", 32'(S_READY), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    RSTB = 1'b1;
    repeat (2) @(negedge CLK);

    // Single-word frame: 5A then A5.
    wq = {16'hA55A};
    run_frame(5'd0, 5'd0, 4'd0, 1'b0);
    check("t1_no_gap", 32'(gapq.size()), 32'd0);

    // 2x2x2 frame, back-to-back words 1..8.
    wq = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
    run_frame(5'd1, 5'd1, 4'd0, 1'b0);
    check("t2_contiguous", 32'(gapq.size()), 32'd0);

    // GAP=3: three idle cycles, ready only in the third.
    wq = {16'h1122, 16'h3344, 16'h5566};
    run_frame(5'd0, 5'd2, 4'd3, 1'b0);
    check("t3_gap_count", 32'(gapq.size()), 32'd2);
    foreach (gapq[i]) check("t3_gap_len", 32'(gapq[i]), 32'd3);
    foreach (maskq[i]) check("t3_ready_pattern", 32'(maskq[i]), 32'h04);

    // Random S_VALID: no bubbles inside a word, 8 beats.
    wq = {16'hC3A1, 16'h0FF0, 16'h8001, 16'h7E24};
    run_frame(5'd1, 5'd0, 4'd0, 1'b1);

    // ABORT during the second beat of word 2.
    dn0 = done_cnt;
    start_frame(5'd1, 5'd0, 4'd0);
    push_word(16'hDEAD, 1'b0);
    push_word(16'hBEEF, 1'b0);
    @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort_out_valid", 32'(OUT_VALID), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_out_spike", 32'(OUT_SPIKE), 32'd0);
    check("abort_s_ready", 32'(S_READY), 32'd0);
    repeat (4) @(negedge CLK);
    check("abort_no_done", 32'(done_cnt - dn0), 32'd0);
    check("abort_scoreboard", 32'(exp_q.size()), 32'd0);
    wq = {16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1A1B};
    run_frame(5'd1, 5'd0, 4'd0, 1'b0);

    // START while busy is ignored: frame stays at 2 words.
    dn0 = done_cnt;
    frame_beats = 0;
    start_frame(5'd0, 5'd1, 4'd0);
    push_word(16'h1234, 1'b0);
    HW = 5'd3; T = 5'd3; GAP = 4'd5; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    push_word(16'h5678, 1'b0);
    finish_frame(dn0, 2);

    // Asynchronous reset mid-frame.
    dn0 = done_cnt;
    start_frame(5'd1, 5'd1, 4'd0);
    push_word(16'h9A9B, 1'b0);
    #2 RSTB = 1'b0;
    #1;
    check("arst_out_valid", 32'(OUT_VALID), 32'd0);
    check("arst_out_spike", 32'(OUT_SPIKE), 32'd0);
    check("arst_busy", 32'(BUSY), 32'd0);
    check("arst_s_ready", 32'(S_READY), 32'd0);
    check("arst_done", 32'(DONE), 32'd0);
    exp_q.delete();
    @(negedge CLK);
    RSTB = 1'b1;
    repeat (4) @(negedge CLK);
    check("arst_no_done", 32'(done_cnt - dn0), 32'd0);
    check("arst_idle_busy", 32'(BUSY), 32'd0);
    wq = {16'hBEEF};
    run_frame(5'd0, 5'd0, 4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spike_tx.md
# spike_tx

Host-side transmitter for the layer spike input port: accepts 16-bit spike words over a valid/ready stream and serializes each word into the narrow IN_VALID/IN_SPIKE beat protocol that the layer's input shift register deserializes (low byte first, 2^CNT_WIDTH beats per word). It counts words against the layer geometry, enforces a programmable inter-word gap, and flags frame completion. It sits between the test/host interface and a layer_ctrl instance (or between two chained layers).

## Interface
- IO_WIDTH, 8, beat width on the serial side
- CNT_WIDTH, 1, log2 of beats per word; word width WORD_WIDTH = IO_WIDTH << CNT_WIDTH (16), derived localparam
- HW_WIDTH, 5, width of HW (H-1 = W-1)
- T_WIDTH, 5, width of T (timesteps-1)
- GAP_WIDTH, 4, width of GAP

- CLK  in  1  clock, all logic on rising edge
- RSTB  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle pulse; begins a frame, latches HW/T/GAP; ignored while BUSY
- ABORT  in  1  synchronous abort; overrides START
- HW  in  HW_WIDTH  frame height-1 and width-1
- T  in  T_WIDTH  timesteps-1
- GAP  in  GAP_WIDTH  minimum idle cycles between words
- S_VALID  in  1  spike word available
- S_READY  out  1  word accepted when S_VALID & S_READY
- S_SPIKE  in  WORD_WIDTH  spike word
- OUT_VALID  out  1  beat valid, registered
- OUT_SPIKE  out  IO_WIDTH  beat data, registered; 0 when OUT_VALID low
- BUSY  out  1  frame in progress
- DONE  out  1  one-cycle pulse at frame end

## Operation
- Words per frame N = (HW+1)*(HW+1)*(T+1); loop order t innermost, then column, then row; counters t_cnt, col_cnt, row_cnt compared against latched values (no multiplier).
- States: IDLE, LOAD, SEND, GAP.
- IDLE: BUSY=0, S_READY=0. START -> LOAD, latch HW/T/GAP, clear counters.
- LOAD: S_READY=1. On handshake: capture S_SPIKE into shift register, beat_cnt=0 -> SEND.
- SEND: OUT_VALID=1, OUT_SPIKE = shift_reg[IO_WIDTH-1:0] (low byte first), shift right by IO_WIDTH each beat. On last beat (beat_cnt = 2^CNT_WIDTH-1): advance word counters; if last word -> IDLE with DONE pulse next cycle; else GAP=0 -> S_READY=1 in this cycle, handshake reloads shift register and stays in SEND (back-to-back), no handshake -> LOAD; GAP>0 -> GAP.
- GAP: OUT_VALID=0, gap counter runs; S_READY=1 only in the GAP-th idle cycle; handshake there -> SEND, otherwise -> LOAD.
- S_READY is never asserted after the last word of a frame is accepted.
- ABORT (any state): next cycle IDLE, OUT_VALID=0, OUT_SPIKE=0, counters cleared, no DONE; partially sent word discarded.
- START while BUSY: ignored, no state change.

## Timing
- Reset: state IDLE; S_READY, OUT_VALID, BUSY, DONE = 0; OUT_SPIKE = 0; shift register and all counters 0.
- START at cycle c -> BUSY=1, S_READY=1 from c+1.
- Handshake at cycle n -> beats at n+1 .. n+2^CNT_WIDTH.
- GAP=0, S_VALID held high: continuous OUT_VALID for the whole frame (2N beats).
- GAP=g>0, S_VALID held high: exactly g OUT_VALID-low cycles between words.
- S_VALID low: OUT_VALID stays low until the handshake; each word is still sent contiguously once started (no mid-word bubbles).
- DONE high the cycle after the final beat; BUSY falls in that same cycle.
- Reset mid-frame: immediate return to reset values, no DONE.

## Structure
- Shared package: state encoding (IDLE/LOAD/SEND/GAP), WORD_WIDTH derivation, beats-per-word constant; shared with the receive-side shift register so the byte order is defined in one place.
- One natural sub-module: spike_tx_frame_cnt (t/col/row counters, last-word flag); serializer and FSM stay in the top.

## Test plan
- HW=0, T=0, GAP=0, S_SPIKE=16'hA55A -> beats 8'h5A then 8'hA5 on consecutive cycles, DONE the next cycle, one handshake total.
- HW=1, T=1, GAP=0, S_VALID held high, words 1..8 -> 16 contiguous OUT_VALID beats, low byte first each word, DONE once, S_READY low after word 8.
- HW=0, T=2, GAP=3 -> exactly 3 OUT_VALID-low cycles between words; S_READY high only in the 3rd idle cycle.
- S_VALID toggled randomly during frame HW=1, T=0 -> no OUT_VALID bubble inside a word; beat data and count (8) unchanged.
- ABORT during the second beat of word 2 -> OUT_VALID=0 and BUSY=0 next cycle, no DONE; new START runs a full frame correctly.
- START pulsed while BUSY and RSTB asserted mid-frame -> START ignored; reset forces all outputs to 0 asynchronously.
